bf_pixel_collector: RTL and testbench

BF_PIXEL_COLLECTOR -- requirements
Module: bf_pixel_collector

---
 rtl/bf_pixel_collector.sv | 112 +++++++++++
 tb/tb_bf_pixel_collector.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_pixel_collector.sv
// Captures one frame of beamformed samples into a local buffer, then streams them
// back out in capture order over a valid/ready handshake.
module bf_pixel_collector #(
    parameter int PIXELS = 64,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 17
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overflow
);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        wrPtr_q, wrPtr_d;
    logic [ADDR_W-1:0]        rdPtr_q, rdPtr_d;
    logic                     overflow_q, overflow_d;
    logic                     frameDone_q, frameDone_d;
    logic                     memWrite;
    logic signed [DATA_W-1:0] mem [PIXELS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            overflow_q  <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            overflow_q  <= overflow_d;
            frameDone_q <= frameDone_d;
        end
    end

    // The buffer has no reset; a frame is only read out after every slot was rewritten.
    always_ff @(posedge clk) begin
        if (memWrite && !rst) begin
            mem[wrPtr_q] <= in_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        overflow_d  = overflow_q;
        frameDone_d = 1'b0;
        memWrite    = 1'b0;
        case (state_q)
            IDLE: begin
                // A sample arriving together with start is dropped silently.
                if (start) begin
                    state_d    = CAPTURE;
                    wrPtr_d    = '0;
                    overflow_d = 1'b0;
                end else if (in_valid) begin
                    overflow_d = 1'b1;
                end
            end
            CAPTURE: begin
                if (in_valid) begin
                    memWrite = 1'b1;
                    wrPtr_d  = wrPtr_q + ADDR_W'(1);
                    if (wrPtr_q == LAST_ADDR) begin
                        state_d = DRAIN;
                        rdPtr_d = '0;
                    end
                end
            end
            DRAIN: begin
                if (in_valid) begin
                    overflow_d = 1'b1;
                end
                if (out_ready) begin
                    rdPtr_d = rdPtr_q + ADDR_W'(1);
                    if (rdPtr_q == LAST_ADDR) begin
                        state_d     = IDLE;
                        frameDone_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid  = (state_q == DRAIN);
    assign out_data   = out_valid ? mem[rdPtr_q] : '0;
    assign out_last   = out_valid && (rdPtr_q == LAST_ADDR);
    assign busy       = (state_q != IDLE);
    assign frame_done = frameDone_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_bf_pixel_collector.sv
// Directed bench for bf_pixel_collector: a queue-based frame model checked every
// cycle, plus literal expectations for each scenario.
module tb_bf_pixel_collector;

    localparam int PIXELS = 4;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 17;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              frame_done;
    logic              overflow;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    bit                mCapturing;
    logic [DATA_W-1:0] mCapQ[$];
    logic [DATA_W-1:0] mDrainQ[$];
    bit                mOverflow;
    bit                mFrameDone;

    logic [DATA_W-1:0] xferLog[$];
    bit                lastLog[$];
    int                fdCount;
    int                drainCycles;

    always #5 clk = ~clk;

    bf_pixel_collector #(
        .PIXELS(PIXELS),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .frame_done(frame_done),
        .overflow  (overflow)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame model: samples accumulate in a capture queue and move to a drain queue once full.
    always @(posedge clk) begin
        bit fd;
        fd = 1'b0;
        if (rst) begin
            mCapturing = 1'b0;
            mCapQ.delete();
            mDrainQ.delete();
            mOverflow = 1'b0;
        end else if (mDrainQ.size() > 0) begin
            if (in_valid) mOverflow = 1'b1;
            if (out_ready) begin
                mDrainQ.delete(0);
                if (mDrainQ.size() == 0) fd = 1'b1;
            end
        end else if (mCapturing) begin
            if (in_valid) begin
                mCapQ.push_back(in_data);
                if (mCapQ.size() == PIXELS) begin
                    mDrainQ = mCapQ;
                    mCapQ.delete();
                    mCapturing = 1'b0;
                end
            end
        end else if (start) begin
            mCapturing = 1'b1;
            mCapQ.delete();
            mOverflow = 1'b0;
        end else if (in_valid) begin
            mOverflow = 1'b1;
        end
        mFrameDone = fd;
    end

    always @(negedge clk) begin
        if (checkEn) begin
            bit                dr;
            logic [DATA_W-1:0] expData;
            dr      = (mDrainQ.size() > 0);
            expData = dr ? mDrainQ[0] : '0;
            checkOutput("model_out_valid", 32'(out_valid), 32'(dr));
            checkOutput("model_out_data", 32'(out_data), 32'(expData));
            checkOutput("model_out_last", 32'(out_last), 32'(dr && mDrainQ.size() == 1));
            checkOutput("model_busy", 32'(busy), 32'(mCapturing || dr));
            checkOutput("model_frame_done", 32'(frame_done), 32'(mFrameDone));
            checkOutput("model_overflow", 32'(overflow), 32'(mOverflow));
        end
        if (frame_done === 1'b1) fdCount++;
        if (out_valid === 1'b1) drainCycles++;
    end

    // Inputs change 1ns after the falling edge; handshakes are logged just before the rising edge.
    task automatic applyStimulus(input logic s, input logic v, input logic [DATA_W-1:0] d, input logic r);
        start     = s;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        if (out_valid === 1'b1 && out_ready) begin
            xferLog.push_back(out_data);
            lastLog.push_back(out_last);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n, input logic r);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, r);
    endtask

    task automatic captureFour(input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                               input logic [DATA_W-1:0] d2, input logic [DATA_W-1:0] d3,
                               input logic r);
        applyStimulus(1'b0, 1'b1, d0, r);
        applyStimulus(1'b0, 1'b1, d1, r);
        applyStimulus(1'b0, 1'b1, d2, r);
        applyStimulus(1'b0, 1'b1, d3, r);
    endtask

    task automatic checkLog(input string name, input logic [DATA_W-1:0] e0, input logic [DATA_W-1:0] e1,
                            input logic [DATA_W-1:0] e2, input logic [DATA_W-1:0] e3);
        logic [DATA_W-1:0] exp [4];
        exp = '{e0, e1, e2, e3};
        checkOutput({name, "_count"}, 32'(xferLog.size()), 32'(4));
        for (int i = 0; i < 4; i++) begin
            checkOutput({name, "_data"}, (i < xferLog.size()) ? 32'(xferLog[i]) : 'x, 32'(exp[i]));
            checkOutput({name, "_last"}, (i < lastLog.size()) ? 32'(lastLog[i]) : 'x, 32'(i == 3));
        end
        xferLog.delete();
        lastLog.delete();
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        rst     = 1'b0;
        checkEn = 1'b1;
        checkOutput("reset_busy", 32'(busy), 32'(0));
        checkOutput("reset_out_valid", 32'(out_valid), 32'(0));
        checkOutput("reset_out_data", 32'(out_data), 32'(0));
        checkOutput("reset_overflow", 32'(overflow), 32'(0));

        $display("[TB] basic frame");
        fdCount = 0;
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        captureFour(DATA_W'(-5), DATA_W'(100), DATA_W'(-65536), DATA_W'(65535), 1'b1);
        checkOutput("basic_drain_start", 32'(out_valid), 32'(1));
        idleCycles(6, 1'b1);
        checkLog("basic", DATA_W'(-5), DATA_W'(100), DATA_W'(-65536), DATA_W'(65535));
        checkOutput("basic_frame_done_count", 32'(fdCount), 32'(1));
        checkOutput("basic_busy_after", 32'(busy), 32'(0));

        $display("[TB] backpressure");
        drainCycles = 0;
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        captureFour(DATA_W'(7), DATA_W'(8), DATA_W'(9), DATA_W'(10), 1'b0);
        checkOutput("bp_first_data", 32'(out_data), 32'(7));
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, '0, (i % 2) == 1);
        checkOutput("bp_drain_cycles", 32'(drainCycles), 32'(8));
        checkLog("bp", DATA_W'(7), DATA_W'(8), DATA_W'(9), DATA_W'(10));

        $display("[TB] gapped input");
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b1, DATA_W'(11), 1'b1);
        applyStimulus(1'b0, 1'b0, DATA_W'(17'h1ABCD), 1'b1);
        applyStimulus(1'b0, 1'b0, DATA_W'(17'h1ABCD), 1'b1);
        applyStimulus(1'b0, 1'b1, DATA_W'(22), 1'b1);
        applyStimulus(1'b0, 1'b1, DATA_W'(33), 1'b1);
        applyStimulus(1'b0, 1'b0, DATA_W'(17'h1ABCD), 1'b1);
        checkOutput("gap_not_yet_drain", 32'(out_valid), 32'(0));
        checkOutput("gap_still_busy", 32'(busy), 32'(1));
        applyStimulus(1'b0, 1'b1, DATA_W'(44), 1'b1);
        checkOutput("gap_drain_now", 32'(out_valid), 32'(1));
        checkOutput("gap_first_data", 32'(out_data), 32'(11));
        idleCycles(6, 1'b1);
        checkLog("gap", DATA_W'(11), DATA_W'(22), DATA_W'(33), DATA_W'(44));

        $display("[TB] overflow");
        applyStimulus(1'b0, 1'b1, DATA_W'(17'h00ABC), 1'b1);
        checkOutput("ovf_idle", 32'(overflow), 32'(1));
        applyStimulus(1'b1, 1'b1, DATA_W'(777), 1'b1);
        checkOutput("ovf_cleared_by_start", 32'(overflow), 32'(0));
        checkOutput("ovf_start_busy", 32'(busy), 32'(1));
        captureFour(DATA_W'(1), DATA_W'(2), DATA_W'(3), DATA_W'(4), 1'b0);
        applyStimulus(1'b0, 1'b1, DATA_W'(555), 1'b0);
        checkOutput("ovf_drain", 32'(overflow), 32'(1));
        checkOutput("ovf_drain_hold", 32'(out_data), 32'(1));
        idleCycles(6, 1'b1);
        checkLog("ovf", DATA_W'(1), DATA_W'(2), DATA_W'(3), DATA_W'(4));
        checkOutput("ovf_sticky", 32'(overflow), 32'(1));

        $display("[TB] reset mid-capture");
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b1, DATA_W'(50), 1'b1);
        applyStimulus(1'b0, 1'b1, DATA_W'(60), 1'b1);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, DATA_W'(70), 1'b1);
        rst = 1'b0;
        checkOutput("rst_busy", 32'(busy), 32'(0));
        checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
        checkOutput("rst_out_data", 32'(out_data), 32'(0));
        checkOutput("rst_out_last", 32'(out_last), 32'(0));
        checkOutput("rst_frame_done", 32'(frame_done), 32'(0));
        checkOutput("rst_overflow", 32'(overflow), 32'(0));
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        captureFour(DATA_W'(81), DATA_W'(82), DATA_W'(83), DATA_W'(84), 1'b1);
        idleCycles(6, 1'b1);
        checkLog("rst_new", DATA_W'(81), DATA_W'(82), DATA_W'(83), DATA_W'(84));

        $display("[TB] reset mid-drain");
        fdCount = 0;
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        captureFour(DATA_W'(5), DATA_W'(6), DATA_W'(7), DATA_W'(8), 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, DATA_W'(9), 1'b1);
        rst = 1'b0;
        checkOutput("rst_drain_busy", 32'(busy), 32'(0));
        checkOutput("rst_drain_out_valid", 32'(out_valid), 32'(0));
        idleCycles(2, 1'b1);
        checkOutput("rst_drain_no_done", 32'(fdCount), 32'(0));
        xferLog.delete();
        lastLog.delete();

        $display("[TB] ignored start");
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b1, DATA_W'(91), 1'b1);
        applyStimulus(1'b0, 1'b1, DATA_W'(92), 1'b1);
        applyStimulus(1'b1, 1'b1, DATA_W'(93), 1'b1);
        checkOutput("ign_capture_busy", 32'(busy), 32'(1));
        checkOutput("ign_capture_no_drain", 32'(out_valid), 32'(0));
        applyStimulus(1'b1, 1'b1, DATA_W'(94), 1'b0);
        checkOutput("ign_drain_entered", 32'(out_valid), 32'(1));
        checkOutput("ign_drain_first", 32'(out_data), 32'(91));
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        checkOutput("ign_drain_hold", 32'(out_data), 32'(91));
        checkOutput("ign_overflow", 32'(overflow), 32'(0));
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        checkOutput("ign_drain_second", 32'(out_data), 32'(92));
        idleCycles(5, 1'b1);
        checkLog("ign", DATA_W'(91), DATA_W'(92), DATA_W'(93), DATA_W'(94));
        checkOutput("ign_busy_after", 32'(busy), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
